// File: rtl/ql_fifo_pkg.sv
// Shared constants for the QuickLogic synchronous FIFO model: FFLAGS bit
// positions and the legal DEPTH_LOG2 range.
package ql_fifo_pkg;

    localparam int unsigned FLAG_EMPTY  = 0;
    localparam int unsigned FLAG_AEMPTY = 1;
    localparam int unsigned FLAG_AFULL  = 2;
    localparam int unsigned FLAG_FULL   = 3;

    localparam int unsigned DEPTH_LOG2_MIN = 1;
    localparam int unsigned DEPTH_LOG2_MAX = 12;

endpackage

// File: rtl/ql_fifo_ctrl.sv
// FIFO control path: read/write pointers, occupancy count, push/pop acceptance,
// status flags and one-cycle overflow/underflow pulses.
module ql_fifo_ctrl
    import ql_fifo_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 9,
    parameter int unsigned CW         = DEPTH_LOG2 + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_wen,
    input  logic                  i_ren,
    input  logic                  i_flush,
    input  logic [CW-1:0]         i_upae,
    input  logic [CW-1:0]         i_upaf,
    output logic [DEPTH_LOG2-1:0] o_wr_ptr,
    output logic [DEPTH_LOG2-1:0] o_rd_ptr,
    output logic                  o_push,
    output logic                  o_pop,
    output logic [CW-1:0]         o_level,
    output logic [3:0]            o_fflags,
    output logic                  o_overflow,
    output logic                  o_underflow
);

    localparam logic [CW-1:0] DEPTH_C = CW'(2 ** DEPTH_LOG2);

    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic                  r_overflow;
    logic                  r_underflow;

    logic w_full;
    logic w_empty;
    logic w_push_ok;
    logic w_pop_ok;

    assign w_full    = (r_count == DEPTH_C);
    assign w_empty   = (r_count == '0);
    assign w_push_ok = i_wen && !w_full;
    assign w_pop_ok  = i_ren && !w_empty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (i_flush) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + DEPTH_LOG2'(1);
            end
            if (w_push_ok && !w_pop_ok) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop_ok && !w_push_ok) begin
                r_count <= r_count - CW'(1);
            end
            r_overflow  <= i_wen && w_full;
            r_underflow <= i_ren && w_empty;
        end
    end

    // Datapath strobes are suppressed while reset or flush owns the edge.
    assign o_push = rst_n && !i_flush && w_push_ok;
    assign o_pop  = rst_n && !i_flush && w_pop_ok;

    always_comb begin
        o_fflags              = '0;
        o_fflags[FLAG_EMPTY]  = w_empty;
        o_fflags[FLAG_AEMPTY] = (r_count <= i_upae);
        o_fflags[FLAG_AFULL]  = (r_count >= i_upaf);
        o_fflags[FLAG_FULL]   = w_full;
    end

    assign o_wr_ptr    = r_wr_ptr;
    assign o_rd_ptr    = r_rd_ptr;
    assign o_level     = r_count;
    assign o_overflow  = r_overflow;
    assign o_underflow = r_underflow;

endmodule

// File: rtl/ql_sync_fifo.sv
// Parametrised single-clock FIFO with storage array and read-data path.
// Define QL_FIFO_FWFT_EN for first-word fall-through; otherwise RDATA is registered.
module ql_sync_fifo
    import ql_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH_LOG2 = 9,
    localparam int unsigned CW        = DEPTH_LOG2 + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  WEN,
    input  logic [DATA_WIDTH-1:0] WDATA,
    input  logic                  REN,
    output logic [DATA_WIDTH-1:0] RDATA,
    input  logic                  FFLUSH,
    input  logic [CW-1:0]         UPAE,
    input  logic [CW-1:0]         UPAF,
    output logic [3:0]            FFLAGS,
    output logic [CW-1:0]         LEVEL,
    output logic                  OVERFLOW,
    output logic                  UNDERFLOW
);

    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;

    if (DEPTH_LOG2 < DEPTH_LOG2_MIN || DEPTH_LOG2 > DEPTH_LOG2_MAX) begin : g_bad_depth
        $error("ql_sync_fifo: DEPTH_LOG2 out of range");
    end

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic [DEPTH_LOG2-1:0] w_wr_ptr;
    logic [DEPTH_LOG2-1:0] w_rd_ptr;
    logic                  w_push;
    logic                  w_pop;
    logic [CW-1:0]         w_level;

    ql_fifo_ctrl #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .CW         (CW)
    ) u_ctrl (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_wen       (WEN),
        .i_ren       (REN),
        .i_flush     (FFLUSH),
        .i_upae      (UPAE),
        .i_upaf      (UPAF),
        .o_wr_ptr    (w_wr_ptr),
        .o_rd_ptr    (w_rd_ptr),
        .o_push      (w_push),
        .o_pop       (w_pop),
        .o_level     (w_level),
        .o_fflags    (FFLAGS),
        .o_overflow  (OVERFLOW),
        .o_underflow (UNDERFLOW)
    );

    // Storage is never cleared; reset only rewinds the pointers.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[w_wr_ptr] <= WDATA;
        end
    end

`ifdef QL_FIFO_FWFT_EN
    assign RDATA = (w_level != '0) ? r_mem[w_rd_ptr] : '0;
`else
    logic [DATA_WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (w_pop) begin
            r_rdata <= r_mem[w_rd_ptr];
        end
    end

    assign RDATA = r_rdata;
`endif

    assign LEVEL = w_level;

endmodule
